tiny_dnn_mac_array: RTL and testbench

- Parametrised successor to the single-lane real-valued dot-product core.
- N_LANE parallel fixed-point MAC lanes share one activation stream. Each lane has a private weight RAM with a bias slot.
- Adds saturating accumulation, a pipelined update command, and an output-valid strobe.
- Sits between the activation buffer and the layer output buffer; each lane computes one output neuron per pass.

---
 rtl/tiny_dnn_mac_array.sv | 147 ++++++++++++++
 tb/tb_tiny_dnn_mac_array.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_dnn_mac_array.sv
`default_nettype none
// ============================================================================
// Module   : tiny_dnn_mac_array
// Brief    : N_LANE saturating fixed-point MAC lanes sharing one activation
//            stream, per-lane weight RAM with bias slot, 3-stage pipeline.
//            Optional macro TINY_DNN_MAC_RELU_EN clamps published sums at 0.
// Revision : 1.0 - initial release
// ============================================================================
module tiny_dnn_mac_array #(
    parameter int N_LANE = 4,
    parameter int F_SIZE = 1024,
    parameter int DW     = 16,
    parameter int WW     = 16,
    parameter int ACC_W  = 40,
    parameter int ADR_W  = $clog2(F_SIZE),
    parameter int LANE_W = (N_LANE > 1) ? $clog2(N_LANE) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic                    write,
    input  logic                    bwrite,
    input  logic [LANE_W-1:0]       wlane,
    input  logic [ADR_W-1:0]        wa,
    input  logic [WW-1:0]           wd,
    input  logic                    exec,
    input  logic                    bias,
    input  logic [ADR_W-1:0]        ra,
    input  logic                    update,
    input  logic [DW-1:0]           d,
    output logic [N_LANE*ACC_W-1:0] sum,
    output logic                    sum_valid
);

    localparam int                c_PW       = DW + WW;
    localparam logic [ADR_W-1:0]  c_BIAS_ADR = ADR_W'(F_SIZE - 1);
    localparam logic [LANE_W:0]   c_N_LANE   = (LANE_W + 1)'(N_LANE);
    localparam logic [ACC_W-1:0]  c_ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  c_ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    // Command flag bit positions
    localparam int c_INIT = 0;
    localparam int c_EXEC = 1;
    localparam int c_BIAS = 2;
    localparam int c_UPD  = 3;

    logic [3:0]        w_cmd1_d, r_cmd1_q, w_cmd2_d, r_cmd2_q;
    logic [DW-1:0]     w_d1_d, r_d1_q;
    logic              w_sum_valid_d, r_sum_valid_q;
    logic [ADR_W-1:0]  w_radr, w_wadr;
    logic              w_wr_ok;

    always_comb begin
        w_radr           = bias ? c_BIAS_ADR : ra;
        w_wadr           = bwrite ? c_BIAS_ADR : wa;
        w_wr_ok          = write && ({1'b0, wlane} < c_N_LANE);
        // bias takes precedence over a simultaneous exec
        w_cmd1_d         = '0;
        w_cmd1_d[c_INIT] = init;
        w_cmd1_d[c_EXEC] = exec & ~bias;
        w_cmd1_d[c_BIAS] = bias;
        w_cmd1_d[c_UPD]  = update;
        w_cmd2_d         = r_cmd1_q;
        w_d1_d           = d;
        w_sum_valid_d    = r_cmd2_q[c_UPD] & ~r_cmd2_q[c_INIT];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd1_q      <= '0;
            r_cmd2_q      <= '0;
            r_d1_q        <= '0;
            r_sum_valid_q <= 1'b0;
        end else begin
            r_cmd1_q      <= w_cmd1_d;
            r_cmd2_q      <= w_cmd2_d;
            r_d1_q        <= w_d1_d;
            r_sum_valid_q <= w_sum_valid_d;
        end
    end

    assign sum_valid = r_sum_valid_q;

    for (genvar k = 0; k < N_LANE; k++) begin : g_lane
        logic [WW-1:0]           r_mem [F_SIZE];
        logic [WW-1:0]           r_w_q;
        logic signed [WW-1:0]    w_w1_d, r_w1_q;
        logic signed [c_PW-1:0]  w_prod;
        logic [ACC_W:0]          w_addend, w_total;
        logic [ACC_W-1:0]        w_sat, w_acc_d, r_acc_q, w_pub, w_sum_d, r_sum_q;

        // Weight RAM is deliberately unreset; a same-word read sees old data
        always_ff @(posedge clk) begin
            if (w_wr_ok && (wlane == LANE_W'(k))) begin
                r_mem[w_wadr] <= wd;
            end
            r_w_q <= r_mem[w_radr];
        end

        always_comb begin
            w_w1_d   = r_w_q;
            w_prod   = r_w1_q * $signed(r_d1_q);
            w_addend = '0;
            if (r_cmd2_q[c_EXEC]) begin
                w_addend = {{(ACC_W+1-c_PW){w_prod[c_PW-1]}}, w_prod};
            end else if (r_cmd2_q[c_BIAS]) begin
                w_addend = {{(ACC_W+1-WW){r_w1_q[WW-1]}}, r_w1_q};
            end
            w_total = {r_acc_q[ACC_W-1], r_acc_q} + w_addend;
            // Guard bit disagreeing with the sign bit means overflow
            if (w_total[ACC_W] != w_total[ACC_W-1]) begin
                w_sat = w_total[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
            end else begin
                w_sat = w_total[ACC_W-1:0];
            end

            w_acc_d = r_acc_q;
            if (r_cmd2_q[c_INIT]) begin
                w_acc_d = '0;
            end else if (r_cmd2_q[c_EXEC] || r_cmd2_q[c_BIAS]) begin
                w_acc_d = w_sat;
            end

`ifdef TINY_DNN_MAC_RELU_EN
            w_pub = w_acc_d[ACC_W-1] ? '0 : w_acc_d;
`else
            w_pub = w_acc_d;
`endif
            w_sum_d = w_sum_valid_d ? w_pub : r_sum_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_w1_q  <= '0;
                r_acc_q <= '0;
                r_sum_q <= '0;
            end else begin
                r_w1_q  <= w_w1_d;
                r_acc_q <= w_acc_d;
                r_sum_q <= w_sum_d;
            end
        end

        assign sum[k*ACC_W +: ACC_W] = r_sum_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_tiny_dnn_mac_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_tiny_dnn_mac_array
// Brief    : Directed self-checking bench for tiny_dnn_mac_array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tiny_dnn_mac_array;

    localparam int N_LANE = 4;
    localparam int ACC_W  = 40;

    logic                    clk = 1'b0;
    logic                    reset, init, write, bwrite, exec, bias, update;
    logic [1:0]              wlane;
    logic [9:0]              wa, ra;
    logic [15:0]             wd, d;
    logic [N_LANE*ACC_W-1:0] sum;
    logic                    sum_valid;

    int errors = 0;
    int checks = 0;

    tiny_dnn_mac_array dut (
        .clk(clk), .reset(reset), .init(init), .write(write), .bwrite(bwrite),
        .wlane(wlane), .wa(wa), .wd(wd), .exec(exec), .bias(bias), .ra(ra),
        .update(update), .d(d), .sum(sum), .sum_valid(sum_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] lane_sum(input int k);
        return sum[k*ACC_W +: ACC_W];
    endfunction

    task automatic cyc(input logic i_init, input logic i_exec, input logic i_bias,
                       input logic i_upd, input logic [9:0] i_ra, input logic [15:0] i_d);
        init = i_init; exec = i_exec; bias = i_bias; update = i_upd; ra = i_ra; d = i_d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic [15:0] i_d);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, i_d);
    endtask

    task automatic wr(input logic [1:0] lane, input logic [9:0] adr,
                      input logic [15:0] data, input logic bw);
        write = 1'b1; wlane = lane; wa = adr; wd = data; bwrite = bw;
        @(posedge clk); #1;
        write = 1'b0; bwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 0; write = 0; bwrite = 0; exec = 0; bias = 0;
        update = 0; wlane = 0; wa = 0; wd = 0; ra = 0; d = 0;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
        checks++;
        if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sum_valid); end
        reset = 1'b0;
        // Known weights: lanes 1-3 zero, lane0 1,2,3,50,0,2 and bias 10
        for (int l = 1; l < N_LANE; l++) begin
            for (int a = 0; a < 6; a++) wr(2'(l), 10'(a), 16'd0, 1'b0);
            wr(2'(l), 10'd0, 16'd0, 1'b1);
        end
        wr(2'd0, 10'd0, 16'd1, 1'b0);
        wr(2'd0, 10'd1, 16'd2, 1'b0);
        wr(2'd0, 10'd2, 16'd3, 1'b0);
        wr(2'd0, 10'd3, 16'd50, 1'b0);
        wr(2'd0, 10'd4, 16'd0, 1'b0);
        wr(2'd0, 10'd5, 16'd2, 1'b0);
        wr(2'd0, 10'd7, 16'd10, 1'b1);
    endtask

    task automatic test_mac_basic();
        cyc(1, 0, 0, 0, 10'd0, 16'd0);
        cyc(0, 1, 0, 0, 10'd0, 16'd0);
        cyc(0, 1, 0, 0, 10'd1, 16'd4);
        cyc(0, 1, 0, 0, 10'd2, 16'd5);
        cyc(0, 0, 1, 1, 10'd0, 16'd6);
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", sum_valid); end
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", sum_valid); end
        checks++;
        if (lane_sum(0) !== 40'd42) begin errors++; $display("FAIL basic_lane0 got=%0d exp=42", $signed(lane_sum(0))); end
        for (int k = 1; k < N_LANE; k++) begin
            checks++;
            if (lane_sum(k) !== 40'd0) begin errors++; $display("FAIL basic_lane%0d got=%0d exp=0", k, $signed(lane_sum(k))); end
        end
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b0 || lane_sum(0) !== 40'd42) begin
            errors++; $display("FAIL basic_hold valid=%b lane0=%0d exp valid=0 lane0=42", sum_valid, $signed(lane_sum(0)));
        end
    endtask

    task automatic test_bias_priority();
        cyc(1, 0, 0, 0, 10'd0, 16'd0);
        cyc(0, 1, 1, 1, 10'd5, 16'd0);
        idle(16'd3);
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b1 || lane_sum(0) !== 40'd10) begin
            errors++; $display("FAIL bias_priority valid=%b lane0=%0d exp valid=1 lane0=10", sum_valid, $signed(lane_sum(0)));
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        wr(2'd0, 10'd0, 16'd32767, 1'b0);
        cyc(1, 0, 0, 0, 10'd0, 16'd0);
        for (int i = 0; i < 1024; i++) begin
            cyc(0, 1, 0, (i == 1023), 10'd0, 16'd32767);
            if (sum_valid === 1'b1) pulses++;
        end
        idle(16'd32767);
        if (sum_valid === 1'b1) pulses++;
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL sat_no_early_valid got=%0d exp=0", pulses); end
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b1 || lane_sum(0) !== 40'h7F_FFFF_FFFF) begin
            errors++; $display("FAIL sat_lane0 valid=%b got=%h exp=7fffffffff", sum_valid, lane_sum(0));
        end
        checks++;
        if (lane_sum(1) !== 40'd0) begin errors++; $display("FAIL sat_lane1 got=%h exp=0", lane_sum(1)); end
    endtask

    task automatic test_negative();
        logic [ACC_W-1:0] exp_v;
`ifdef TINY_DNN_MAC_RELU_EN
        exp_v = '0;
`else
        exp_v = -40'sd300;
`endif
        wr(2'd0, 10'd0, -16'sd100, 1'b0);
        cyc(1, 0, 0, 0, 10'd0, 16'd0);
        cyc(0, 1, 0, 1, 10'd0, 16'd0);
        idle(16'd3);
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b1 || lane_sum(0) !== exp_v) begin
            errors++; $display("FAIL negative valid=%b got=%0d exp=%0d", sum_valid, $signed(lane_sum(0)), $signed(exp_v));
        end
    endtask

    task automatic test_init_exec();
        cyc(1, 0, 0, 0, 10'd0, 16'd0);
        cyc(0, 1, 0, 1, 10'd3, 16'd0);
        idle(16'd1);
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b1 || lane_sum(0) !== 40'd50) begin
            errors++; $display("FAIL init_exec_pre valid=%b got=%0d exp=50", sum_valid, $signed(lane_sum(0)));
        end
        cyc(1, 1, 0, 1, 10'd3, 16'd0);
        idle(16'd1);
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b0 || lane_sum(0) !== 40'd50) begin
            errors++; $display("FAIL init_exec_novalid valid=%b lane0=%0d exp valid=0 lane0=50", sum_valid, $signed(lane_sum(0)));
        end
        cyc(0, 0, 0, 1, 10'd0, 16'd0);
        idle(16'd0);
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b1 || lane_sum(0) !== 40'd0) begin
            errors++; $display("FAIL init_exec_acc valid=%b got=%0d exp=0", sum_valid, $signed(lane_sum(0)));
        end
    endtask

    task automatic test_back_to_back_collision();
        cyc(1, 0, 0, 0, 10'd0, 16'd0);
        write = 1'b1; wlane = 2'd0; wa = 10'd5; wd = 16'd7; bwrite = 1'b0;
        cyc(0, 1, 0, 1, 10'd5, 16'd0);
        write = 1'b0;
        cyc(0, 1, 0, 1, 10'd5, 16'd1);
        idle(16'd1);
        checks++;
        if (sum_valid !== 1'b1 || lane_sum(0) !== 40'd2) begin
            errors++; $display("FAIL collision_old valid=%b got=%0d exp=2", sum_valid, $signed(lane_sum(0)));
        end
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b1 || lane_sum(0) !== 40'd9) begin
            errors++; $display("FAIL collision_new valid=%b got=%0d exp=9", sum_valid, $signed(lane_sum(0)));
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        cyc(0, 1, 0, 1, 10'd5, 16'd0);
        reset = 1'b1;
        idle(16'd1);
        reset = 1'b0;
        checks++;
        if (sum !== '0 || sum_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_sum valid=%b sum=%h exp valid=0 sum=0", sum_valid, sum);
        end
        for (int i = 0; i < 3; i++) begin
            idle(16'd0);
            if (sum_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_mid_valid got=%0d exp=0", pulses); end
        cyc(0, 0, 0, 1, 10'd0, 16'd0);
        idle(16'd0);
        idle(16'd0);
        checks++;
        if (sum_valid !== 1'b1 || lane_sum(0) !== 40'd0) begin
            errors++; $display("FAIL reset_mid_acc valid=%b got=%0d exp=0", sum_valid, $signed(lane_sum(0)));
        end
    endtask

    initial begin
        test_reset();
        test_mac_basic();
        test_bias_priority();
        test_saturation();
        test_negative();
        test_init_exec();
        test_back_to_back_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
